alu_issue: RTL

- Operand-issue stage that drives the 16-bit ALU.
- Accepts encoded instructions over a valid/ready handshake and reads operands from an internal register file.
- Presents alith/source1/source2 to the ALU from registered outputs, then writes the ALU result back to the destination register.
- Sits between the instruction fetch/queue and the ALU; the ALU stays purely combinational.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_regfile.sv | 36 +++
 rtl/alu_issue.sv | 109 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU operand-issue stage: ALU op codes, instruction field positions
// and the decoded instruction record.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alith_e;

  localparam int INSTR_W     = 16;
  localparam int ALITH_HI    = 15;
  localparam int ALITH_LO    = 14;
  localparam int RD_HI       = 13;
  localparam int RD_LO       = 11;
  localparam int RS1_HI      = 10;
  localparam int RS1_LO      = 8;
  localparam int RS2_HI      = 7;
  localparam int RS2_LO      = 5;
  localparam int IMM_SEL_BIT = 4;
  localparam int IMM_HI      = 3;
  localparam int IMM_LO      = 0;

  typedef struct packed {
    alith_e     alith;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic       imm_sel;
    logic [3:0] imm4;
  } instr_t;

  function automatic instr_t decode(input logic [INSTR_W-1:0] raw);
    instr_t d;
    d.alith   = alith_e'(raw[ALITH_HI:ALITH_LO]);
    d.rd      = raw[RD_HI:RD_LO];
    d.rs1     = raw[RS1_HI:RS1_LO];
    d.rs2     = raw[RS2_HI:RS2_LO];
    d.imm_sel = raw[IMM_SEL_BIT];
    d.imm4    = raw[IMM_HI:IMM_LO];
    return d;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Architectural register file: two combinational operand reads, one debug read and one
// synchronous write port. r0 is hardwired to zero on both the read and write side.
module alu_regfile #(
  parameter int NREGS = 8,
  parameter int DW    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(NREGS)-1:0] raddr1,
  input  logic [$clog2(NREGS)-1:0] raddr2,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [DW-1:0]            rdata1,
  output logic [DW-1:0]            rdata2,
  output logic [DW-1:0]            dbg_data,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [DW-1:0]            wdata
);

  logic [DW-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1   = (raddr1 == '0)   ? '0 : regs[raddr1];
  assign rdata2   = (raddr2 == '0)   ? '0 : regs[raddr2];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Operand-issue stage feeding the combinational 16-bit ALU and writing its result back.
// Build option OPERAND_FWD_EN: bypass alu_out into hazarding operands instead of interlocking.
module alu_issue
  import alu_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int DW    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [INSTR_W-1:0]       instr,
  input  logic                     stall,
  output logic [1:0]               alith,
  output logic [DW-1:0]            source1,
  output logic [DW-1:0]            source2,
  output logic                     ex_valid,
  input  logic [DW-1:0]            alu_out,
  output logic [15:0]              retire_count,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [DW-1:0]            dbg_data
);

  localparam int AW = $clog2(NREGS);

  instr_t        dec;
  logic [AW-1:0] rs1;
  logic [AW-1:0] rs2;
  logic [AW-1:0] rd;
  logic [AW-1:0] rd_ex;
  logic [DW-1:0] rdata1;
  logic [DW-1:0] rdata2;
  logic [DW-1:0] imm_ext;
  logic [DW-1:0] op1;
  logic [DW-1:0] op2;
  logic          accept;
  logic          writeback;
  logic          hit1;
  logic          hit2;

  assign dec     = decode(instr);
  assign rs1     = AW'(dec.rs1);
  assign rs2     = AW'(dec.rs2);
  assign rd      = AW'(dec.rd);
  assign imm_ext = DW'(dec.imm4);

  // The instruction in EX retires on any edge where it is not held by stall.
  assign writeback = ex_valid && !stall;
  assign hit1      = writeback && (rd_ex != '0) && (rd_ex == rs1);
  assign hit2      = writeback && (rd_ex != '0) && !dec.imm_sel && (rd_ex == rs2);

  alu_regfile #(
    .NREGS (NREGS),
    .DW    (DW)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .raddr1   (rs1),
    .raddr2   (rs2),
    .dbg_addr (dbg_addr),
    .rdata1   (rdata1),
    .rdata2   (rdata2),
    .dbg_data (dbg_data),
    .we       (writeback),
    .waddr    (rd_ex),
    .wdata    (alu_out)
  );

`ifdef OPERAND_FWD_EN
  assign instr_ready = !stall;
  assign op1         = hit1 ? alu_out : rdata1;
  assign op2         = dec.imm_sel ? imm_ext : (hit2 ? alu_out : rdata2);
`else
  // Interlock: hold off the reader for one cycle so it sees the register after writeback.
  assign instr_ready = !stall && !(instr_valid && (hit1 || hit2));
  assign op1         = rdata1;
  assign op2         = dec.imm_sel ? imm_ext : rdata2;
`endif

  assign accept = instr_valid && instr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alith    <= '0;
      source1  <= '0;
      source2  <= '0;
      rd_ex    <= '0;
      ex_valid <= 1'b0;
    end else if (!stall) begin
      ex_valid <= accept;
      if (accept) begin
        alith   <= dec.alith;
        source1 <= op1;
        source2 <= op2;
        rd_ex   <= rd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_count <= '0;
    end else if (writeback) begin
      retire_count <= retire_count + 16'd1;
    end
  end

endmodule
